// File: rtl/register.sv
// register -- WIDTH-bit parallel-load / right-shift register.
// Priority at each rising clk edge: rst, then load_en, then shift_en, then hold.
// A shift moves shift_in into the MSB and drops q[0] out of the LSB.
// Optional feature (macro REGISTER_SHIFT_OUT_EN): a registered shift_out port
// that captures the bit leaving the LSB on every shift edge.

module register #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_en,
   input  logic             shift_en,
   input  logic             shift_in,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
`ifdef REGISTER_SHIFT_OUT_EN
   ,
   output logic             shift_out
`endif
);

   // Right-shifted image of q with shift_in entering the MSB. Built per bit so
   // that WIDTH=1 degenerates cleanly to "q becomes shift_in" without ever
   // referencing an out-of-range slice.
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] q_next;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_shift
         if (gi == WIDTH - 1) begin : g_msb
            assign shifted[gi] = shift_in;
         end else begin : g_lower
            assign shifted[gi] = q[gi + 1];
         end
      end
   endgenerate

   // Next-value select: load wins over shift, otherwise hold.
   always_comb begin
      q_next = q;
      if (load_en) begin
         q_next = d;
      end else if (shift_en) begin
         q_next = shifted;
      end
   end

   // Data flops: synchronous reset overrides every other operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else begin
         q <= q_next;
      end
   end

`ifdef REGISTER_SHIFT_OUT_EN
   // shift_out captures the outgoing LSB only on true shift edges; loads and
   // holds leave it untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_out <= 1'b0;
      end else if (!load_en && shift_en) begin
         shift_out <= q[0];
      end
   end
`endif

endmodule

// File: tb/tb_register.sv
// tb_register -- self-checking bench for register (WIDTH=8 and WIDTH=1 instances).
// Directed steps followed by a randomized run, all checked against a
// behavioural model kept as plain integers. Handles REGISTER_SHIFT_OUT_EN
// being either defined or undefined.

module tb_register;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       load_en = 1'b0;
   logic       shift_en = 1'b0;
   logic       shift_in = 1'b0;
   logic [7:0] d = 8'h00;
   logic [7:0] q;
   logic [0:0] q1;
`ifdef REGISTER_SHIFT_OUT_EN
   logic       shift_out;
   logic       shift_out1;
`endif

   int passed = 0;
   int total  = 0;

   // behavioural model state
   int m8  = 0;
   int m1  = 0;
   int so8 = 0;
   int so1 = 0;

   always #5 clk = ~clk;

   register #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .load_en(load_en), .shift_en(shift_en),
      .shift_in(shift_in), .d(d), .q(q)
`ifdef REGISTER_SHIFT_OUT_EN
      , .shift_out(shift_out)
`endif
   );

   register #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .load_en(load_en), .shift_en(shift_en),
      .shift_in(shift_in), .d(d[0:0]), .q(q1)
`ifdef REGISTER_SHIFT_OUT_EN
      , .shift_out(shift_out1)
`endif
   );

   task automatic check(input string tag, input int got, input int exp);
      total++;
      assert (got === exp) passed++;
      else begin
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one edge with the currently driven inputs, update the model,
   // and compare both instances against it.
   task automatic cyc(input string tag);
      int old8, old1;
      old8 = m8;
      old1 = m1;
      @(posedge clk);
      #1;
      if (rst) begin
         m8 = 0; m1 = 0; so8 = 0; so1 = 0;
      end else if (load_en) begin
         m8 = int'(d);
         m1 = int'(d) % 2;
      end else if (shift_en) begin
         m8 = (old8 / 2) + (shift_in ? 128 : 0);
         m1 = shift_in ? 1 : 0;
         so8 = old8 % 2;
         so1 = old1;
      end
      $display("%0t %s rst=%0b ld=%0b sh=%0b si=%0b d=%02h -> q=%02h q1=%0b",
               $time, tag, rst, load_en, shift_en, shift_in, d, q, q1);
      check({tag, ".q"}, int'(q), m8);
      check({tag, ".q1"}, int'(q1), m1);
`ifdef REGISTER_SHIFT_OUT_EN
      check({tag, ".so"}, int'(shift_out), so8);
      check({tag, ".so1"}, int'(shift_out1), so1);
`endif
   endtask

   task automatic drive(input logic r, input logic l, input logic s,
                        input logic si, input logic [7:0] dv);
      rst = r; load_en = l; shift_en = s; shift_in = si; d = dv;
   endtask

   logic [7:0] exp_seq [3];
   logic [7:0] held;
   int         so_before;

   initial begin
      // Reset with load asserted and d=FF still clears q.
      drive(1, 1, 0, 0, 8'hFF);
      cyc("reset");
      check("reset_const", int'(q), 0);

      // Load 0xAA, then hold two edges.
      drive(0, 1, 0, 0, 8'hAA);
      cyc("load");
      check("load_const", int'(q), 8'hAA);
      drive(0, 0, 0, 1, 8'h00);
      cyc("hold0");
      cyc("hold1");
      check("hold_const", int'(q), 8'hAA);

      // Three shifts with shift_in=0: 55, 2A, 15 (shift_out 0, 1, 0).
      exp_seq[0] = 8'h55; exp_seq[1] = 8'h2A; exp_seq[2] = 8'h15;
      drive(0, 0, 1, 0, 8'h00);
      for (int i = 0; i < 3; i++) begin
         cyc("shift");
         check("shift_const", int'(q), int'(exp_seq[i]));
`ifdef REGISTER_SHIFT_OUT_EN
         check("shift_out_const", int'(shift_out), (i == 1) ? 1 : 0);
`endif
      end

      // Serial fill from 0 with shift_in=1: 80, C0, ... FF.
      drive(1, 0, 0, 0, 8'h00);
      cyc("clr");
      drive(0, 0, 1, 1, 8'h00);
      for (int i = 1; i <= 8; i++) begin
         cyc("fill");
         check("fill_const", int'(q), (8'hFF << (8 - i)) & 8'hFF);
      end

      // Load beats shift; shift_out unchanged.
      drive(0, 1, 0, 0, 8'h0F);
      cyc("ld0f");
`ifdef REGISTER_SHIFT_OUT_EN
      so_before = int'(shift_out);
`else
      so_before = 0;
`endif
      drive(0, 1, 1, 1, 8'h3C);
      cyc("prio");
      check("prio_const", int'(q), 8'h3C);
`ifdef REGISTER_SHIFT_OUT_EN
      check("prio_so_hold", int'(shift_out), so_before);
`endif

      // rst pulse between edges has no effect.
      drive(0, 0, 0, 0, 8'h00);
      held = q;
      @(negedge clk);
      rst = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      check("rst_between_edges", int'(q), int'(held));
      cyc("after_glitch");

      // Mid-run reset aborts a shift sequence; shifting resumes from 0.
      drive(0, 1, 0, 0, 8'hAA);
      cyc("ldaa");
      drive(0, 0, 1, 0, 8'h00);
      cyc("run0");
      cyc("run1");
      drive(1, 0, 1, 1, 8'h00);
      cyc("midrst");
      check("midrst_const", int'(q), 0);
      drive(0, 0, 1, 1, 8'h00);
      cyc("resume");
      check("resume_const", int'(q), 8'h80);

      // Randomized run against the model.
      for (int i = 0; i < 300; i++) begin
         drive(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 1) == 1), 1'($urandom), 8'($urandom));
         cyc("rand");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
